// File: rtl/siso_frame_rx.sv
// siso_frame_rx: tick-paced serial receiver for the slow shift link.
// One sample per internal tick (gated by en). A frame is a high start bit,
// WIDTH data bits LSB first, then a low stop bit. A good frame updates
// data_out and pulses data_valid. A high stop bit pulses frame_err instead.
module siso_frame_rx #(
  parameter int TICK_DIV = 100_000_000,
  parameter int WIDTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             si,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic             busy,
  output logic             tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bcnt;
  logic [WIDTH-1:0] shift;
  logic             sample;

  // A sample is the registered tick qualified by en at the same edge.
  assign sample = en & tick;

  // Free-running tick divider; en never affects its phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

  // Frame FSM: advances only on samples; strobes default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bcnt       <= '0;
      shift      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (sample) begin
        case (state)
          IDLE: begin
            if (si) begin
              state <= DATA;
              bcnt  <= '0;
              busy  <= 1'b1;
            end
          end
          DATA: begin
            // LSB arrives first, so shift in from the top.
            shift <= {si, shift[WIDTH-1:1]};
            bcnt  <= bcnt + BW'(1);
            if (bcnt == BIT_LAST) state <= STOP;
          end
          STOP: begin
            // A high stop bit is an error, not a new start bit.
            if (!si) begin
              data_out   <= shift;
              data_valid <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_siso_frame_rx.sv
// Bench for siso_frame_rx. A frame-level model predicts events into a
// scoreboard. A negedge monitor checks tick phase, busy and every strobe.
module tb_siso_frame_rx;
  localparam int TD = 4;
  localparam int W  = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b1;
  logic         si  = 1'b0;
  logic [W-1:0] data_out;
  logic         data_valid, frame_err, busy, tick;

  siso_frame_rx #(.TICK_DIV(TD), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .si(si),
    .data_out(data_out), .data_valid(data_valid),
    .frame_err(frame_err), .busy(busy), .tick(tick)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   rel   = 0;
  logic rst_d = 1'b1;

  typedef struct {
    bit           is_err;
    logic [W-1:0] data;
    int           c;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;

  // Frame-level reference state.
  bit           m_busy = 0;
  int           m_n    = 0;
  logic [W-1:0] m_word = '0;
  logic [W-1:0] m_good = '0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= rst;
    rel   <= rst ? 0 : rel + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", nm, act, req, cyc);
    end
  endtask

  // Consumes one sampled bit taken at clock edge number c.
  function automatic void model(input logic b, input int c);
    if (!m_busy) begin
      if (b) begin
        m_busy = 1;
        m_n    = 0;
        m_word = '0;
      end
    end else if (m_n < W) begin
      m_word[m_n] = b;
      m_n++;
    end else begin
      if (!b) begin
        sb.push_back('{1'b0, m_word, c});
        m_good = m_word;
      end else begin
        sb.push_back('{1'b1, m_good, c});
      end
      m_busy = 0;
    end
  endfunction

  // Monitor: reset state, tick phase, busy, and scoreboard events.
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (rst_d) begin
        chk("reset_outs", {24'h0, data_out, data_valid, frame_err, busy, tick}, 32'h0);
      end else begin
        chk("tick_phase", {31'h0, tick}, {31'h0, (rel % TD) == 0});
        chk("busy", {31'h0, busy}, {31'h0, m_busy});
        if (data_valid || frame_err) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event actual=v%0b/e%0b required=none cyc=%0d",
                     data_valid, frame_err, cyc);
          end else begin
            e_mon = sb.pop_front();
            chk("evt_valid", {31'h0, data_valid}, {31'h0, !e_mon.is_err});
            chk("evt_err", {31'h0, frame_err}, {31'h0, e_mon.is_err});
            chk("evt_data", {28'h0, data_out}, {28'h0, e_mon.data});
            chk("evt_cycle", cyc, e_mon.c);
          end
        end
      end
    end
  end

  // Present one bit on the next tick, with si/en jittering between ticks.
  task automatic put(input logic b, input logic e);
    int n = 0;
    int ec;
    @(negedge clk);
    while (!tick && n < 4 * TD) begin
      si = 1'($urandom);
      en = 1'($urandom);
      n++;
      @(negedge clk);
    end
    if (!tick) begin
      total++;
      bad++;
      $display("FAIL tick_timeout actual=0 required=1 cyc=%0d", cyc);
    end
    si = b;
    en = e;
    ec = cyc + 1;
    @(posedge clk);
    if (e) model(b, ec);
  endtask

  // Deliver a bit, randomly stalling with en=0 ticks first (p_off percent).
  task automatic put_bit(input logic b, input int p_off);
    logic e;
    do begin
      e = ($urandom_range(99) >= p_off);
      put(e ? b : 1'($urandom), e);
    end while (!e);
  endtask

  task automatic frame(input logic [W-1:0] d, input logic stop, input int p_off);
    put_bit(1'b1, p_off);
    for (int i = 0; i < W; i++) put_bit(d[i], p_off);
    put_bit(stop, p_off);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    m_busy = 0;
    m_good = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset held three edges, then idle ticks with si low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) put(1'b0, 1'b1);

    // Good frame 4'b1101.
    frame(4'b1101, 1'b0, 0);
    put(1'b0, 1'b1);

    // Framing error; data_out must hold 4'b1101.
    frame(4'b0110, 1'b1, 0);
    put(1'b0, 1'b1);

    // Back-to-back frames.
    frame(4'h3, 1'b0, 0);
    frame(4'hA, 1'b0, 0);
    put(1'b0, 1'b1);

    // Enable gating after the second data bit, frame 0x9.
    put(1'b1, 1'b1);
    put(1'b1, 1'b1);
    put(1'b0, 1'b1);
    repeat (3) put(1'($urandom), 1'b0);
    put(1'b0, 1'b1);
    put(1'b1, 1'b1);
    put(1'b0, 1'b1);
    put(1'b0, 1'b1);

    // Reset in the middle of DATA, then a clean 0x5.
    put(1'b1, 1'b1);
    put(1'b1, 1'b1);
    put(1'b0, 1'b1);
    do_reset(1);
    frame(4'h5, 1'b0, 0);
    put(1'b0, 1'b1);

    // Randomized traffic: idle gaps, en stalls, occasional bad stop bits.
    for (int k = 0; k < 40; k++) begin
      for (int j = 0; j < int'($urandom_range(2)); j++) put_bit(1'b0, 20);
      frame(W'($urandom), $urandom_range(9) == 0, 20);
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
